// File: rtl/gray_win3x3.sv
// gray_win3x3 -- streaming 3x3 neighbourhood generator for gray video.
// Two line buffers supply the two rows above the current pixel; each of the
// three row taps feeds a 3-deep column shift register. The window is emitted
// two pixel_clk cycles after the input beat that completes it.
module gray_win3x3 #(
  parameter int DATA_WIDTH = 10,
  parameter int IMG_WIDTH  = 1920
) (
  input  logic                    pixel_clk,
  input  logic                    rst_n,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tuser,
  input  logic                    s_axis_tlast,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tuser,
  output logic                    m_axis_tlast,
  output logic [9*DATA_WIDTH-1:0] m_axis_tdata,
  output logic                    overflow_err
);

  localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);

  // Line position and frame bookkeeping
  logic [COL_W-1:0] col_reg, col_next, col_eff;
  logic [1:0]       row_reg, row_next, row_eff;
  logic             line_full_reg, line_full_next;  // col already parked at the last slot
  logic             in_frame_reg, in_frame_next;    // a tuser has been seen since reset
  logic             started_reg, started_next;      // first window of this frame issued
  logic             overflow_reg, overflow_next;

  // Beat classification for the current cycle
  logic accept, ovf_beat, lb_we, out_beat, out_user, collision;

  // Stage 1: values registered on the accepting edge
  logic                  s1_valid_reg, s1_out_reg, s1_user_reg, s1_last_reg;
  logic                  s1_first_reg, s1_we_reg;
  logic [DATA_WIDTH-1:0] s1_pix_reg;
  logic [COL_W-1:0]      s1_addr_reg;
  logic                  byp_sel_reg;
  logic [DATA_WIDTH-1:0] byp_data_reg;

  // Line buffers with registered read ports
  logic [DATA_WIDTH-1:0] lb1_mem [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb2_mem [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb1_rd_reg, lb2_rd_reg;

  // Row taps: 0 = two lines up, 1 = previous line, 2 = current line
  logic [DATA_WIDTH-1:0] row_tap [3];

  // Next-state for the position counters and flags; only accepted beats move them
  always_comb begin
    accept         = s_axis_tvalid;
    col_eff        = s_axis_tuser ? '0 : col_reg;
    row_eff        = s_axis_tuser ? 2'd0 : row_reg;
    ovf_beat       = accept && !s_axis_tuser && line_full_reg;
    lb_we          = accept && !ovf_beat;
    in_frame_next  = in_frame_reg | (accept & s_axis_tuser);
    out_beat       = accept && in_frame_next && (row_eff == 2'd2);
    out_user       = out_beat && !started_reg;
    // LB2 is written one cycle late; a back-to-back beat at the same column
    // must see that pending write rather than the stale RAM word.
    collision      = accept && s1_we_reg && (s1_addr_reg == col_eff);
    col_next       = col_reg;
    row_next       = row_reg;
    line_full_next = line_full_reg;
    started_next   = started_reg;
    overflow_next  = overflow_reg;
    if (accept) begin
      started_next = (s_axis_tuser ? 1'b0 : started_reg) | out_beat;
      if (s_axis_tlast) begin
        col_next       = '0;
        row_next       = (row_eff == 2'd2) ? 2'd2 : row_eff + 2'd1;
        line_full_next = 1'b0;
      end else if (col_eff == COL_LAST) begin
        col_next       = col_eff;
        row_next       = row_eff;
        line_full_next = 1'b1;
      end else begin
        col_next       = col_eff + COL_W'(1);
        row_next       = row_eff;
        line_full_next = 1'b0;
      end
      if (ovf_beat) begin
        overflow_next = 1'b1;
      end
    end
  end

  // Position counters, frame flags and the stage-1 pipeline registers
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      col_reg       <= '0;
      row_reg       <= '0;
      line_full_reg <= 1'b0;
      in_frame_reg  <= 1'b0;
      started_reg   <= 1'b0;
      overflow_reg  <= 1'b0;
      s1_valid_reg  <= 1'b0;
      s1_out_reg    <= 1'b0;
      s1_user_reg   <= 1'b0;
      s1_last_reg   <= 1'b0;
      s1_first_reg  <= 1'b0;
      s1_we_reg     <= 1'b0;
      s1_pix_reg    <= '0;
      s1_addr_reg   <= '0;
      byp_sel_reg   <= 1'b0;
      byp_data_reg  <= '0;
    end else begin
      col_reg       <= col_next;
      row_reg       <= row_next;
      line_full_reg <= line_full_next;
      in_frame_reg  <= in_frame_next;
      started_reg   <= started_next;
      overflow_reg  <= overflow_next;
      s1_valid_reg  <= accept;
      s1_out_reg    <= out_beat;
      s1_user_reg   <= out_user;
      s1_last_reg   <= accept & s_axis_tlast;
      s1_first_reg  <= accept && (col_eff == '0);
      s1_we_reg     <= lb_we;
      if (accept) begin
        s1_pix_reg   <= s_axis_tdata;
        s1_addr_reg  <= col_eff;
        byp_sel_reg  <= collision;
        byp_data_reg <= lb1_rd_reg;
      end
    end
  end

  // LB1: read-first, so the word read out is the previous line's pixel
  always_ff @(posedge pixel_clk) begin
    if (accept) begin
      lb1_rd_reg <= lb1_mem[col_eff];
    end
    if (lb_we) begin
      lb1_mem[col_eff] <= s_axis_tdata;
    end
  end

  // LB2: receives the word LB1 gave up, one cycle after the beat
  always_ff @(posedge pixel_clk) begin
    if (accept) begin
      lb2_rd_reg <= lb2_mem[col_eff];
    end
    if (s1_we_reg) begin
      lb2_mem[s1_addr_reg] <= lb1_rd_reg;
    end
  end

  // Select the three row taps feeding the column shift registers
  always_comb begin
    row_tap[0] = byp_sel_reg ? byp_data_reg : lb2_rd_reg;
    row_tap[1] = lb1_rd_reg;
    row_tap[2] = s1_pix_reg;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_row
      logic [DATA_WIDTH-1:0] c0_reg, c1_reg, c2_reg;  // c0 = current column

      // Shift this row's tap in; the first beat of a line clears the left columns
      always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
          c0_reg <= '0;
          c1_reg <= '0;
          c2_reg <= '0;
        end else if (s1_valid_reg) begin
          c0_reg <= row_tap[gi];
          c1_reg <= s1_first_reg ? '0 : c0_reg;
          c2_reg <= s1_first_reg ? '0 : c1_reg;
        end
      end

      assign m_axis_tdata[(3*gi+0)*DATA_WIDTH +: DATA_WIDTH] = c2_reg;
      assign m_axis_tdata[(3*gi+1)*DATA_WIDTH +: DATA_WIDTH] = c1_reg;
      assign m_axis_tdata[(3*gi+2)*DATA_WIDTH +: DATA_WIDTH] = c0_reg;
    end
  endgenerate

  // Output qualifiers, aligned with the window held in the shift registers
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      m_axis_tvalid <= s1_out_reg;
      m_axis_tuser  <= s1_user_reg;
      m_axis_tlast  <= s1_out_reg & s1_last_reg;
    end
  end

  assign overflow_err = overflow_reg;

endmodule

// File: tb/tb_gray_win3x3.sv
// tb_gray_win3x3 -- directed vector tables plus hand sequences for gray_win3x3.
module tb_gray_win3x3;
  localparam int DW = 10;
  localparam int IW = 8;

  logic           pixel_clk;
  logic           rst_n;
  logic           s_axis_tvalid, s_axis_tuser, s_axis_tlast;
  logic [DW-1:0]  s_axis_tdata;
  logic           m_axis_tvalid, m_axis_tuser, m_axis_tlast;
  logic [9*DW-1:0] m_axis_tdata;
  logic           overflow_err;

  int tests = 0;
  int fails = 0;

  // One record per input cycle: the stimulus and what its output beat must look like
  typedef struct {
    logic            v, u, l;
    logic [DW-1:0]   d;
    logic            ev, eu, el;
    logic [9*DW-1:0] ew;
  } vec_t;

  vec_t tab[$];

  gray_win3x3 #(.DATA_WIDTH(DW), .IMG_WIDTH(IW)) dut (
    .pixel_clk     (pixel_clk),
    .rst_n         (rst_n),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tdata  (s_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .overflow_err  (overflow_err)
  );

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  task automatic chk(input string name, input logic [9*DW-1:0] act, input logic [9*DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic u, input logic l, input int d);
    s_axis_tvalid = v;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tdata  = DW'(d);
  endtask

  task automatic step();
    @(posedge pixel_clk);
    #1;
  endtask

  // Expected window for a frame whose pixel (r,c) is base + r*stride + c
  function automatic logic [9*DW-1:0] win(input int base, input int stride, input int r, input int c);
    logic [9*DW-1:0] w;
    w = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        int cc;
        int rr;
        cc = c - 2 + j;
        rr = r - 2 + i;
        if (cc >= 0) w[(3*i+j)*DW +: DW] = DW'(base + rr*stride + cc);
      end
    end
    return w;
  endfunction

  function automatic vec_t mk(input logic v, input logic u, input logic l, input int d,
                              input logic ev, input logic eu, input logic el,
                              input logic [9*DW-1:0] ew);
    vec_t t;
    t.v = v; t.u = u; t.l = l; t.d = DW'(d);
    t.ev = ev; t.eu = eu; t.el = el; t.ew = ew;
    return t;
  endfunction

  // Append nbeats of line r (line length len); row index saturates at 2 in the DUT
  task automatic add_line(input int base, input int stride, input int r, input int nbeats,
                          input int len, input bit user, input bit gaps);
    for (int c = 0; c < nbeats; c++) begin
      tab.push_back(mk(1'b1, user && (c == 0), c == len - 1, base + r*stride + c,
                       r >= 2, (r == 2) && (c == 0), (r >= 2) && (c == len - 1),
                       win(base, stride, r, c)));
      if (gaps) tab.push_back(mk(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, '0));
    end
  endtask

  task automatic add_frame(input int base, input int rows, input int cols, input bit gaps);
    for (int r = 0; r < rows; r++) add_line(base, 16, r, cols, cols, r == 0, gaps);
  endtask

  // Apply each record, then check its output one sample later (two cycles after the beat)
  task automatic run_table(input string name);
    for (int k = 0; k <= tab.size(); k++) begin
      vec_t e;
      if (k < tab.size()) drive(tab[k].v, tab[k].u, tab[k].l, int'(tab[k].d));
      else drive(1'b0, 1'b0, 1'b0, 0);
      step();
      if (k >= 1) begin
        e = tab[k-1];
        chk({name, " tvalid"}, m_axis_tvalid, e.ev);
        if (e.ev) begin
          chk({name, " tuser"}, m_axis_tuser, e.eu);
          chk({name, " tlast"}, m_axis_tlast, e.el);
          chk({name, " tdata"}, m_axis_tdata, e.ew);
          $display("[TB] %s rec %0d: tuser=%0b tlast=%0b tdata=%h", name, k - 1,
                   m_axis_tuser, m_axis_tlast, m_axis_tdata);
        end
      end
    end
    tab.delete();
  endtask

  initial begin
    logic [9*DW-1:0] ew;

    // Reset state
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 0);
    step();
    step();
    chk("reset tvalid", m_axis_tvalid, 1'b0);
    chk("reset tuser", m_axis_tuser, 1'b0);
    chk("reset tlast", m_axis_tlast, 1'b0);
    chk("reset tdata", m_axis_tdata, '0);
    chk("reset overflow", overflow_err, 1'b0);
    rst_n = 1'b1;
    step();

    // 4x4 frame, continuous and with tvalid gaps
    add_frame(0, 4, 4, 1'b0);
    run_table("frame4x4");
    add_frame(0, 4, 4, 1'b1);
    run_table("frame4x4_gaps");

    // One-pixel lines back to back
    ew = '0;
    ew[2*DW +: DW] = DW'(11);
    ew[5*DW +: DW] = DW'(22);
    ew[8*DW +: DW] = DW'(33);
    tab.push_back(mk(1'b1, 1'b1, 1'b1, 11, 1'b0, 1'b0, 1'b0, '0));
    tab.push_back(mk(1'b1, 1'b0, 1'b1, 22, 1'b0, 1'b0, 1'b0, '0));
    tab.push_back(mk(1'b1, 1'b0, 1'b1, 33, 1'b1, 1'b1, 1'b1, ew));
    run_table("one_pixel_lines");

    // tuser injected at row 3, col 1
    add_line(0, 16, 0, 4, 4, 1'b1, 1'b0);
    add_line(0, 16, 1, 4, 4, 1'b0, 1'b0);
    add_line(0, 16, 2, 4, 4, 1'b0, 1'b0);
    add_line(0, 16, 3, 1, 4, 1'b0, 1'b0);
    add_line(500, 16, 0, 4, 4, 1'b1, 1'b0);
    add_line(500, 16, 1, 4, 4, 1'b0, 1'b0);
    add_line(500, 16, 2, 4, 4, 1'b0, 1'b0);
    run_table("tuser_restart");

    // 10-pixel line into an 8-deep line buffer
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, k == 0, k == 9, 100 + k);
      step();
      chk("ovf flag", overflow_err, k >= 8);
      if (k == 7 || k == 8) chk("ovf col hold", dut.col_reg, 7);
      chk("ovf row0 no output", m_axis_tvalid, 1'b0);
      $display("[TB] ovf beat %0d: overflow_err=%0b", k, overflow_err);
    end
    add_line(100, 100, 1, 8, 8, 1'b0, 1'b0);
    add_line(100, 100, 2, 8, 8, 1'b0, 1'b0);
    run_table("ovf_lb_untouched");
    add_frame(0, 4, 4, 1'b0);
    run_table("after_ovf");
    chk("ovf sticky", overflow_err, 1'b1);

    // Reset pulse at row 2, col 2
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) begin
        drive(1'b1, (r == 0) && (c == 0), c == 3, r*16 + c);
        step();
      end
    end
    drive(1'b1, 1'b0, 1'b0, 32);
    step();
    drive(1'b1, 1'b0, 1'b0, 33);
    step();
    chk("rst pre tvalid", m_axis_tvalid, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 34);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst async tvalid", m_axis_tvalid, 1'b0);
    chk("rst async tuser", m_axis_tuser, 1'b0);
    chk("rst async tlast", m_axis_tlast, 1'b0);
    chk("rst async tdata", m_axis_tdata, '0);
    chk("rst async overflow", overflow_err, 1'b0);
    step();
    chk("rst held tvalid", m_axis_tvalid, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 0);
    rst_n = 1'b1;
    step();
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        drive(1'b1, 1'b0, c == 3, 200 + r*16 + c);
        step();
        chk("no tuser after rst", m_axis_tvalid, 1'b0);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 0);
    step();
    chk("no tuser after rst", m_axis_tvalid, 1'b0);
    step();
    chk("no tuser after rst", m_axis_tvalid, 1'b0);

    // A fresh frame recovers normally
    add_frame(0, 3, 4, 1'b0);
    run_table("post_reset_frame");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
